bird_motion_ctrl: RTL and testbench
===================================

Name: bird_motion_ctrl

Overview:
Sequencer for the bird sprite's vertical motion. On every frame tick it applies gravity and any pending flap, computes the new y, and schedules the shared VGA sprite drawer: erase at the old y, then draw at the new y. It detects floor and pipe collisions and holds the game in a dead state until restart. It sits between the rate divider, KEY inputs and the sprite drawer.

Parameters:
Y_W, 7, width of bird_y (screen rows 0..119)
V_W, 5, width of signed velocity
Y_START, 60, initial y on start/restart
Y_MAX, 112, floor row; reaching it is a collision
FLAP_V, 4, upward speed set by a flap (velocity becomes -FLAP_V)
GRAV, 1, velocity increment per tick
V_TERM, 6, maximum downward velocity

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
tick  in  1  one-cycle frame pulse from the rate divider
flap  in  1  level, active-high (inverted KEY), edge-detected inside
start  in  1  one-cycle pulse: start from IDLE, or restart from DEAD
collide  in  1  level from pipe logic, sampled in UPDATE
draw_req  out  1  request to the sprite drawer
draw_erase  out  1  1 = erase (background colour), 0 = draw bird; valid while draw_req=1
draw_y  out  Y_W  sprite row; valid while draw_req=1
draw_ack  in  1  drawer done, one-cycle pulse
bird_y  out  Y_W  committed bird y
velocity  out  V_W  signed current velocity (positive = downward)
dead  out  1  high in DEAD
overrun  out  1  sticky: a tick arrived while one was already pending

Behaviour:
- Synchronous active-low reset, applied on clk edge when resetn=0. Reset values: state=IDLE, bird_y=Y_START, velocity=0, draw_req=0, draw_erase=0, draw_y=0, dead=0, overrun=0, flap_pend=0, tick_pend=0, flap_prev=0.
- Flap edge detect: flap & ~flap_prev sets flap_pend. flap_pend is cleared only in UPDATE (consumed), on start, and on reset. Edges in DEAD/IDLE are ignored.
- tick sets tick_pend in any state except IDLE/DEAD. If tick arrives while tick_pend=1, set overrun (sticky until reset). A single pending tick is kept and ticks never queue deeper.
- States:
  - IDLE: wait for start, then bird_y=Y_START, velocity=0, go to DRAW.
  - WAIT_TICK: when tick_pend=1, clear it and go to ERASE.
  - ERASE: draw_req=1, draw_erase=1, draw_y=bird_y. Stay until draw_ack, then go to UPDATE.
  - UPDATE (1 cycle): compute the new velocity and y (rules below). If collision, go to DEAD_DRAW, else DRAW.
  - DRAW: draw_req=1, draw_erase=0, draw_y=bird_y. On draw_ack go to WAIT_TICK.
  - DEAD_DRAW: same as DRAW. On draw_ack go to DEAD.
  - DEAD: dead=1. On start: bird_y=Y_START, velocity=0, clear flags, go to ERASE_RST.
  - ERASE_RST: erase at the crash position (draw_y = y latched before restart), then go to DRAW.
- Handshake rules:
  - draw_req is registered and rises the cycle the state is entered.
  - draw_y and draw_erase are stable while draw_req=1.
  - draw_ack is sampled only while draw_req=1; draw_req drops the cycle after ack.
  - draw_ack outside a request is ignored.
- UPDATE arithmetic, signed, width Y_W+2:
  - v' = flap_pend ? -FLAP_V : min(velocity+GRAV, V_TERM). Gravity does not apply on a flap tick.
  - y' = bird_y + v'.
  - If y' < 0: bird_y=0, velocity=0 (ceiling clamp, not fatal).
  - Else if y' ≥ Y_MAX: bird_y=Y_MAX, velocity=0, collision.
  - Otherwise bird_y=y', velocity=v'.
  - collide=1 in UPDATE is a collision; position is still updated.
- Latency: tick in WAIT_TICK → draw_req (erase) 2 cycles later. With an ack after 1 cycle of req, a full erase+update+draw completes in ≥6 cycles.
- Simultaneous events:
  - tick and start in IDLE: start wins and the tick is dropped.
  - flap edge in the same cycle as UPDATE: goes to next tick's pend (the flap_pend value sampled in UPDATE is the pre-edge one).
- Reset mid-handshake aborts immediately (draw_req=0). The drawer must tolerate an abandoned request.

Decomposition:
- Shared package bird_pkg: state encoding localparams, Y_W/V_W, screen constants (Y_MAX, Y_START), and the physics constants shared with the pipe/collision logic.
- One sub-module, edge_pulse (rising-edge detector, registered), reused for flap and for KEY inputs elsewhere.

Test Plan:
1. Reset, start, ack each req after 1 cycle → draw at y=60; after tick: erase y=60, then draw y=61 with velocity=1.
2. Ticks 2,3 with no flap → y=63 (v=2), then y=66 (v=3); 10 further ticks → velocity saturates at 6 and stays 6.
3. From y=61, v=1, flap pulse then tick → velocity=-4, draw_y=57; next tick → v=-3, y=54.
4. y=2, flap, tick → y'=-2 clamps to bird_y=0, velocity=0, dead=0.
5. Fall to floor: y=110, v=6 → bird_y=112, DEAD_DRAW, then dead=1. A tick in DEAD has no effect. start → erase y=112, draw y=60, dead=0.
6. Hold draw_ack low 20 cycles with 2 ticks during ERASE → draw_y/draw_erase stable, overrun=1, exactly one extra update after completion. resetn=0 mid-req → draw_req=0 the next cycle, state=IDLE.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared constants, state encoding and the per-tick motion rule for the bird.
// The pipe/collision logic imports the same screen and physics constants.
package bird_pkg;

  localparam int Y_W     = 7;        // screen rows 0..119
  localparam int V_W     = 5;        // signed velocity
  localparam int A_W     = Y_W + 2;  // signed working width for the update
  localparam int Y_START = 60;
  localparam int Y_MAX   = 112;      // floor row
  localparam int FLAP_V  = 4;
  localparam int GRAV    = 1;
  localparam int V_TERM  = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_ERASE,
    S_UPDATE,
    S_DRAW,
    S_DEAD_DRAW,
    S_DEAD,
    S_ERASE_RST
  } state_t;

  typedef struct packed {
    logic [Y_W-1:0]        y;
    logic signed [V_W-1:0] v;
    logic                  hit;   // floor reached
  } motion_t;

  // One frame of motion: flap or gravity, then ceiling clamp or floor hit.
  function automatic motion_t next_motion(input logic [Y_W-1:0]        y,
                                          input logic signed [V_W-1:0] v,
                                          input logic                  flap);
    logic signed [A_W-1:0] v_n;
    logic signed [A_W-1:0] y_n;
    motion_t               m;
    if (flap) begin
      v_n = -A_W'(FLAP_V);
    end else begin
      v_n = {{(A_W-V_W){v[V_W-1]}}, v} + A_W'(GRAV);
      if (v_n > A_W'(V_TERM)) v_n = A_W'(V_TERM);
    end
    y_n = $signed({2'b00, y}) + v_n;
    if (y_n < 0) begin
      m.y   = '0;
      m.v   = '0;
      m.hit = 1'b0;
    end else if (y_n >= A_W'(Y_MAX)) begin
      m.y   = Y_W'(Y_MAX);
      m.v   = '0;
      m.hit = 1'b1;
    end else begin
      m.y   = y_n[Y_W-1:0];
      m.v   = v_n[V_W-1:0];
      m.hit = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: registered history, pulse high for the first cycle
// the input is seen high.
module edge_pulse (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!resetn) prev <= 1'b0;
    else         prev <= din;
  end

  assign pulse = din & ~prev;

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird vertical-motion sequencer: per frame tick, erase old sprite, apply
// physics, draw new sprite; detects floor/pipe collisions and parks in DEAD.
module bird_motion_ctrl
  import bird_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  tick,
  input  logic                  flap,
  input  logic                  start,
  input  logic                  collide,
  output logic                  draw_req,
  output logic                  draw_erase,
  output logic [Y_W-1:0]        draw_y,
  input  logic                  draw_ack,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] velocity,
  output logic                  dead,
  output logic                  overrun
);

  state_t  state;
  logic    flap_edge;
  logic    flap_pend;
  logic    tick_pend;
  logic    active;
  motion_t nxt;

  edge_pulse u_flap_edge (
    .clk   (clk),
    .resetn(resetn),
    .din   (flap),
    .pulse (flap_edge)
  );

  assign active = (state != S_IDLE) && (state != S_DEAD);
  assign nxt    = next_motion(bird_y, velocity, flap_pend);

  // NOTE: all state updates use non-blocking assignments so every branch
  // below sees the values from the start of the cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      bird_y     <= Y_W'(Y_START);
      velocity   <= '0;
      draw_req   <= 1'b0;
      draw_erase <= 1'b0;
      draw_y     <= '0;
      dead       <= 1'b0;
      overrun    <= 1'b0;
      flap_pend  <= 1'b0;
      tick_pend  <= 1'b0;
    end else begin
      if (active && tick) begin
        tick_pend <= 1'b1;
        if (tick_pend) overrun <= 1'b1;
      end
      if (active && flap_edge) flap_pend <= 1'b1;

      case (state)
        S_IDLE: if (start) begin
          bird_y     <= Y_W'(Y_START);
          velocity   <= '0;
          flap_pend  <= 1'b0;
          tick_pend  <= 1'b0;
          draw_req   <= 1'b1;
          draw_erase <= 1'b0;
          draw_y     <= Y_W'(Y_START);
          state      <= S_DRAW;
        end
        S_WAIT_TICK: if (tick_pend) begin
          tick_pend  <= tick;
          draw_req   <= 1'b1;
          draw_erase <= 1'b1;
          draw_y     <= bird_y;
          state      <= S_ERASE;
        end
        S_ERASE: if (draw_ack) begin
          draw_req <= 1'b0;
          state    <= S_UPDATE;
        end
        S_UPDATE: begin
          // A flap edge landing this cycle belongs to the next tick.
          flap_pend  <= flap_edge;
          bird_y     <= nxt.y;
          velocity   <= nxt.v;
          draw_req   <= 1'b1;
          draw_erase <= 1'b0;
          draw_y     <= nxt.y;
          state      <= (nxt.hit || collide) ? S_DEAD_DRAW : S_DRAW;
        end
        S_DRAW, S_DEAD_DRAW: begin
          if (!draw_req) begin
            // Entered straight from a finished erase: re-raise after a gap.
            draw_req   <= 1'b1;
            draw_erase <= 1'b0;
            draw_y     <= bird_y;
          end else if (draw_ack) begin
            draw_req <= 1'b0;
            if (state == S_DEAD_DRAW) begin
              dead  <= 1'b1;
              state <= S_DEAD;
            end else begin
              state <= S_WAIT_TICK;
            end
          end
        end
        S_DEAD: if (start) begin
          bird_y     <= Y_W'(Y_START);
          velocity   <= '0;
          flap_pend  <= 1'b0;
          tick_pend  <= 1'b0;
          dead       <= 1'b0;
          draw_req   <= 1'b1;
          draw_erase <= 1'b1;
          draw_y     <= bird_y;
          state      <= S_ERASE_RST;
        end
        S_ERASE_RST: if (draw_ack) begin
          draw_req <= 1'b0;
          state    <= S_DRAW;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Self-checking bench for bird_motion_ctrl: a behavioural drawer that acks
// requests and logs them, a table of hand-computed frames, and a random run.
module tb_bird_motion_ctrl;

  localparam int YS = 60;
  localparam int YM = 112;
  localparam int FV = 4;
  localparam int GV = 1;
  localparam int VT = 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic       flap = 1'b0;
  logic       start = 1'b0;
  logic       collide = 1'b0;
  logic       draw_ack = 1'b0;
  logic       draw_req;
  logic       draw_erase;
  logic [6:0] draw_y;
  logic [6:0] bird_y;
  logic [4:0] velocity;
  logic       dead;
  logic       overrun;

  always #5 clk = ~clk;

  bird_motion_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .tick      (tick),
    .flap      (flap),
    .start     (start),
    .collide   (collide),
    .draw_req  (draw_req),
    .draw_erase(draw_erase),
    .draw_y    (draw_y),
    .draw_ack  (draw_ack),
    .bird_y    (bird_y),
    .velocity  (velocity),
    .dead      (dead),
    .overrun   (overrun)
  );

  typedef struct {
    bit erase;
    int y;
  } req_t;

  typedef struct {
    bit flap;
    int y;
    int v;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  req_t log_q[$];
  int   ack_delay = 1;
  int   stab_err = 0;
  int   m_y = YS;
  int   m_v = 0;
  bit   m_dead = 1'b0;
  bit   in_req = 1'b0;
  bit   cur_e;
  int   cur_y;
  int   ack_cnt;
  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drawer model: acks each request after ack_delay cycles, logs it, and
  // counts any change of row/colour while a request is held.
  initial begin : drawer
    forever begin
      @(negedge clk);
      if (!resetn || !draw_req) begin
        draw_ack = 1'b0;
        in_req   = 1'b0;
      end else if (draw_ack) begin
        draw_ack = 1'b0;
      end else begin
        if (!in_req) begin
          in_req  = 1'b1;
          cur_e   = draw_erase;
          cur_y   = int'(draw_y);
          ack_cnt = 0;
        end else if (draw_erase !== cur_e || int'(draw_y) !== cur_y) begin
          stab_err++;
        end
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          draw_ack = 1'b1;
          log_q.push_back('{cur_e, cur_y});
          in_req = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic pulse_flap();
    @(negedge clk) flap = 1'b1;
    @(negedge clk) flap = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic expect_req(input bit e, input int y, input string nm);
    int t = 0;
    while (log_q.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (log_q.size() == 0) begin
      check({nm, "_timeout"}, 0, 1);
    end else begin
      req_t r;
      r = log_q.pop_front();
      check({nm, "_erase"}, int'(r.erase), int'(e));
      check({nm, "_y"}, r.y, y);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string nm);
    repeat (cycles) @(negedge clk);
    check({nm, "_no_req_logged"}, log_q.size(), 0);
    check({nm, "_req_low"}, int'(draw_req), 0);
  endtask

  // Frame physics straight from the rules: flap or capped gravity, then
  // ceiling clamp or floor collision.
  task automatic model_step(input bit f, input bit col);
    int v;
    int y;
    v = f ? -FV : ((m_v + GV > VT) ? VT : m_v + GV);
    y = m_y + v;
    m_dead = col;
    if (y < 0) begin
      y = 0;
      v = 0;
    end else if (y >= YM) begin
      y = YM;
      v = 0;
      m_dead = 1'b1;
    end
    m_y = y;
    m_v = v;
  endtask

  task automatic settle_check(input string nm);
    repeat (2) @(negedge clk);
    check({nm, "_bird_y"}, int'(bird_y), m_y);
    check({nm, "_velocity"}, int'($signed(velocity)), m_v);
    check({nm, "_dead"}, int'(dead), int'(m_dead));
  endtask

  task automatic step(input bit f, input bit col, input string nm);
    if (f) pulse_flap();
    collide = col;
    pulse_tick();
    expect_req(1'b1, m_y, {nm, "_erase"});
    model_step(f, col);
    expect_req(1'b0, m_y, {nm, "_draw"});
    collide = 1'b0;
    settle_check(nm);
  endtask

  task automatic restart(input string nm);
    int crash;
    crash = m_y;
    pulse_start();
    expect_req(1'b1, crash, {nm, "_erase_crash"});
    expect_req(1'b0, YS, {nm, "_draw_start"});
    m_y = YS;
    m_v = 0;
    m_dead = 1'b0;
    settle_check(nm);
  endtask

  task automatic do_reset();
    @(negedge clk) resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    log_q.delete();
    m_y = YS;
    m_v = 0;
    m_dead = 1'b0;
  endtask

  initial begin : main
    int lat;
    int guard;

    vecs = '{'{1'b0, 61, 1}, '{1'b1, 57, -4}, '{1'b0, 54, -3}, '{1'b0, 52, -2},
             '{1'b0, 51, -1}, '{1'b0, 51, 0}, '{1'b0, 52, 1}, '{1'b0, 54, 2},
             '{1'b0, 57, 3}, '{1'b0, 61, 4}, '{1'b0, 66, 5}, '{1'b0, 72, 6},
             '{1'b0, 78, 6}, '{1'b0, 84, 6}};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_draw_req", int'(draw_req), 0);
    check("rst_draw_erase", int'(draw_erase), 0);
    check("rst_draw_y", int'(draw_y), 0);
    check("rst_bird_y", int'(bird_y), YS);
    check("rst_velocity", int'($signed(velocity)), 0);
    check("rst_dead", int'(dead), 0);
    check("rst_overrun", int'(overrun), 0);
    resetn = 1'b1;

    // Tick in IDLE does nothing; start and tick together drop the tick.
    pulse_tick();
    expect_quiet(5, "idle_tick");
    @(negedge clk) begin start = 1'b1; tick = 1'b1; end
    @(negedge clk) begin start = 1'b0; tick = 1'b0; end
    expect_req(1'b0, YS, "start_draw");
    settle_check("start");
    expect_quiet(6, "start_tick_dropped");

    // Table of hand-computed frames; the first also measures tick latency.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].flap) pulse_flap();
      if (i == 0) begin
        pulse_tick();
        lat = 1;
        while (!draw_req && lat < 10) begin
          @(negedge clk);
          lat++;
        end
        check("tick_to_erase_latency", lat, 2);
      end else begin
        pulse_tick();
      end
      expect_req(1'b1, m_y, "vec_erase");
      expect_req(1'b0, vecs[i].y, "vec_draw");
      m_y = vecs[i].y;
      m_v = vecs[i].v;
      m_dead = 1'b0;
      settle_check("vec");
    end

    // Ceiling: 84 -> 90, then flaps down to y=2, then a flap clamps at 0.
    step(1'b0, 1'b0, "pre_ceiling");
    repeat (22) step(1'b1, 1'b0, "climb");
    check("at_two_model", m_y, 2);
    step(1'b1, 1'b0, "ceiling");
    check("ceiling_y", int'(bird_y), 0);
    check("ceiling_v", int'($signed(velocity)), 0);

    // Floor: fall until collision, then DEAD ignores tick and flap.
    guard = 0;
    while (!m_dead && guard < 40) begin
      step(1'b0, 1'b0, "fall");
      guard++;
    end
    check("floor_y", int'(bird_y), YM);
    check("floor_dead", int'(dead), 1);
    pulse_tick();
    pulse_flap();
    expect_quiet(6, "dead_tick");
    check("dead_hold_y", int'(bird_y), YM);
    restart("floor_restart");
    step(1'b0, 1'b0, "after_restart");

    // Pipe collision input.
    step(1'b0, 1'b1, "pipe_hit");
    check("pipe_dead", int'(dead), 1);
    restart("pipe_restart");

    // Randomised frames against the model.
    for (int i = 0; i < 40; i++) begin
      ack_delay = $urandom_range(1, 4);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, "rnd");
      if (m_dead) restart("rnd_restart");
    end
    ack_delay = 1;
    check("no_overrun_yet", int'(overrun), 0);

    // Slow drawer with two ticks during one erase.
    do_reset();
    pulse_start();
    expect_req(1'b0, YS, "ovr_start");
    settle_check("ovr_start");
    ack_delay = 20;
    stab_err = 0;
    pulse_tick();
    guard = 0;
    while (!draw_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ovr_req_seen", int'(draw_req), 1);
    pulse_tick();
    repeat (2) @(negedge clk);
    pulse_tick();
    expect_req(1'b1, m_y, "ovr_erase");
    model_step(1'b0, 1'b0);
    expect_req(1'b0, m_y, "ovr_draw");
    settle_check("ovr_first");
    check("ovr_sticky", int'(overrun), 1);
    expect_req(1'b1, m_y, "ovr_extra_erase");
    model_step(1'b0, 1'b0);
    expect_req(1'b0, m_y, "ovr_extra_draw");
    settle_check("ovr_extra");
    expect_quiet(30, "ovr_single_extra");
    check("ovr_stable", stab_err, 0);

    // Reset in the middle of a request.
    ack_delay = 50;
    pulse_tick();
    guard = 0;
    while (!draw_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk) resetn = 1'b0;
    @(negedge clk);
    check("midreq_rst_req", int'(draw_req), 0);
    check("midreq_rst_overrun", int'(overrun), 0);
    check("midreq_rst_y", int'(bird_y), YS);
    resetn = 1'b1;
    log_q.delete();
    ack_delay = 1;
    pulse_tick();
    expect_quiet(6, "midreq_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
